// File: rtl/md_scheduler_pkg.sv
// Shared MD opcode encodings, latency defaults and sequencer states.
// Also used by the E-stage controller decode that produces E_md_op.
package md_scheduler_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_md_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_scheduler_arith.sv
// Combinational multiply/divide producing the pending HI/LO pair.
// keep flags a zero divisor: the commit must leave HI/LO untouched.
module md_arith
  import md_scheduler_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        keep
);

  logic        sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  // Low 64 bits of a 64x64 product of extended operands are exact
  // for both signed and unsigned 32x32 multiplies.
  assign sgn   = (op == MD_MULT);
  assign ext_a = {{32{sgn & a[31]}}, a};
  assign ext_b = {{32{sgn & b[31]}}, b};
  assign prod  = ext_a * ext_b;

  assign sq = $signed(a) / $signed(b);
  assign sr = $signed(a) % $signed(b);
  assign uq = a / b;
  assign ur = a % b;

  always_comb begin
    hi   = '0;
    lo   = '0;
    keep = 1'b0;
    unique case (op)
      MD_MULT, MD_MULTU: begin
        hi = prod[63:32];
        lo = prod[31:0];
      end
      MD_DIV: begin
        if (b == '0) begin
          keep = 1'b1;
        end else begin
          hi = sr;
          lo = sq;
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          keep = 1'b1;
        end else begin
          hi = ur;
          lo = uq;
        end
      end
      default: begin
        hi   = '0;
        lo   = '0;
        keep = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// E-stage MD sequencer: latches results at start, counts latency,
// commits HI/LO and stalls D-stage MD ops while occupied.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_is_md,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_rdata,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_keep;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_keep;

  md_arith u_arith (
    .op   (E_md_op),
    .a    (E_rs_data),
    .b    (E_rt_data),
    .hi   (res_hi),
    .lo   (res_lo),
    .keep (res_keep)
  );

  assign md_busy  = (state == S_RUN);
  assign md_start = is_md_start(E_md_op) && (state == S_IDLE);
  assign md_stall = D_is_md && (md_start || md_busy);

  always_comb begin
    md_rdata = '0;
    if (E_md_op == MD_MFHI) begin
      md_rdata = md_hi;
    end else if (E_md_op == MD_MFLO) begin
      md_rdata = md_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      md_hi     <= '0;
      md_lo     <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_keep <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (md_start) begin
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_keep <= res_keep;
            cnt       <= is_md_mult(E_md_op) ? CW'(MULT_CYCLES)
                                             : CW'(DIV_CYCLES);
            state     <= S_RUN;
          end else if (E_md_op == MD_MTHI) begin
            md_hi <= E_rs_data;
          end else if (E_md_op == MD_MTLO) begin
            md_lo <= E_rs_data;
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            if (!pend_keep) begin
              md_hi <= pend_hi;
              md_lo <= pend_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler with a cycle-window reference model
// checked every cycle plus hand-computed literal expectations.
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_is_md;
  logic        md_start;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] md_rdata;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  int n_cmp = 0;
  int n_err = 0;
  bit comp_en = 1'b0;

  md_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .E_md_op   (E_md_op),
    .E_rs_data (E_rs_data),
    .E_rt_data (E_rt_data),
    .D_is_md   (D_is_md),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .md_stall  (md_stall),
    .md_rdata  (md_rdata),
    .md_hi     (md_hi),
    .md_lo     (md_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the unit is busy in cycles [bs, be]; the result
  // becomes visible in HI/LO in cycle be+1.
  int          cyc = 0;
  int          bs  = 0;
  int          be  = -1;
  bit          mpend = 1'b0;
  bit          mkeep = 1'b0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  logic [31:0] phi;
  logic [31:0] plo;

  function automatic bit m_busy();
    return (cyc >= bs) && (cyc <= be);
  endfunction

  function automatic bit m_isstart(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  always @(posedge clk) begin
    logic [63:0] up;
    longint sa, sb, sp;
    bit b;
    if (reset) begin
      mhi = '0; mlo = '0; bs = 0; be = -1; mpend = 1'b0;
    end else begin
      b = m_busy();
      if (!b && m_isstart(E_md_op)) begin
        mkeep = 1'b0;
        phi = '0; plo = '0;
        sa = longint'(signed'(E_rs_data));
        sb = longint'(signed'(E_rt_data));
        case (E_md_op)
          4'd1: begin sp = sa * sb; phi = sp[63:32]; plo = sp[31:0]; end
          4'd2: begin
            up = {32'b0, E_rs_data} * {32'b0, E_rt_data};
            phi = up[63:32]; plo = up[31:0];
          end
          4'd3: if (E_rt_data == 0) mkeep = 1'b1;
                else begin sp = sa % sb; phi = sp[31:0];
                           sp = sa / sb; plo = sp[31:0]; end
          default: if (E_rt_data == 0) mkeep = 1'b1;
                   else begin phi = E_rs_data % E_rt_data;
                              plo = E_rs_data / E_rt_data; end
        endcase
        bs = cyc + 1;
        be = cyc + ((E_md_op <= 4'd2) ? 5 : 10);
        mpend = 1'b1;
      end else if (!b && E_md_op == 4'd7) begin
        mhi = E_rs_data;
      end else if (!b && E_md_op == 4'd8) begin
        mlo = E_rs_data;
      end
      if (b && cyc == be && mpend) begin
        if (!mkeep) begin mhi = phi; mlo = plo; end
        mpend = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit mb, ms;
    logic [31:0] mrd;
    if (comp_en) begin
      mb  = m_busy();
      ms  = !mb && m_isstart(E_md_op);
      mrd = (E_md_op == 4'd5) ? mhi : (E_md_op == 4'd6) ? mlo : 32'd0;
      chk("m_busy",  64'(md_busy),  64'(mb));
      chk("m_start", 64'(md_start), 64'(ms));
      chk("m_stall", 64'(md_stall), 64'(D_is_md && (ms || mb)));
      chk("m_rdata", 64'(md_rdata), 64'(mrd));
      chk("m_hi",    64'(md_hi),    64'(mhi));
      chk("m_lo",    64'(md_lo),    64'(mlo));
      chk("op_while_busy", 64'(mb && E_md_op >= 4'd1 && E_md_op <= 4'd8),
          64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic d);
    E_md_op = op; E_rs_data = rs; E_rt_data = rt; D_is_md = d;
  endtask

  // Called in the first busy cycle; returns in the first idle cycle.
  task automatic wait_busy(input string nm, input int exp_n,
                           input logic exp_stall);
    int n = 0;
    while (md_busy === 1'b1 && n < 30) begin
      chk({nm, "_stall"}, 64'(md_stall), 64'(exp_stall));
      n++;
      tick();
    end
    chk({nm, "_len"}, 64'(n), 64'(exp_n));
  endtask

  task automatic start_op(input string nm, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic d);
    drive(op, rs, rt, d);
    #1;
    chk({nm, "_start"}, 64'(md_start), 64'd1);
    chk({nm, "_stall0"}, 64'(md_stall), 64'(d));
    tick();
    drive(MD_NONE, 32'd0, 32'd0, d);
  endtask

  initial begin
    reset = 1'b1;
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
    comp_en = 1'b1;
    tick();
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_hi", 64'(md_hi), 64'd0);
    chk("rst_lo", 64'(md_lo), 64'd0);
    reset = 1'b0;
    tick();

    start_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_busy("mult", 5, 1'b0);
    chk("mult_hi", 64'(md_hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(md_lo), 64'hFFFF_FFFA);
    tick();

    start_op("divu", MD_DIVU, 32'd17, 32'd5, 1'b0);
    wait_busy("divu", 10, 1'b0);
    chk("divu_hi", 64'(md_hi), 64'd2);
    chk("divu_lo", 64'(md_lo), 64'd3);

    // Back-to-back: start in the first idle cycle.
    start_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_busy("div", 10, 1'b0);
    chk("div_hi", 64'(md_hi), 64'hFFFF_FFFF);
    chk("div_lo", 64'(md_lo), 64'hFFFF_FFFD);

    drive(MD_MTHI, 32'h11, 32'd0, 1'b0);
    tick();
    drive(MD_MTLO, 32'h22, 32'd0, 1'b0);
    tick();
    start_op("div0", MD_DIV, 32'd5, 32'd0, 1'b0);
    wait_busy("div0", 10, 1'b0);
    chk("div0_hi", 64'(md_hi), 64'h11);
    chk("div0_lo", 64'(md_lo), 64'h22);
    tick();

    start_op("mfl", MD_MULT, 32'd7, 32'd6, 1'b1);
    wait_busy("mfl", 5, 1'b1);
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    #1;
    chk("mflo_rdata", 64'(md_rdata), 64'd42);
    tick();

    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    tick();
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    #1;
    chk("mfhi_rdata", 64'(md_rdata), 64'hDEAD_BEEF);
    tick();

    start_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_busy("multu", 5, 1'b0);
    chk("multu_hi", 64'(md_hi), 64'd1);
    chk("multu_lo", 64'(md_lo), 64'hFFFF_FFFE);
    tick();

    // Reset in busy cycle 3 of a DIV discards the pending result.
    start_op("rdiv", MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    tick();
    chk("rdiv_busy3", 64'(md_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rdiv_busy", 64'(md_busy), 64'd0);
    chk("rdiv_hi", 64'(md_hi), 64'd0);
    chk("rdiv_lo", 64'(md_lo), 64'd0);
    repeat (12) tick();
    chk("rdiv_hi_late", 64'(md_hi), 64'd0);
    chk("rdiv_lo_late", 64'(md_lo), 64'd0);

    comp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts a decoded MD opcode from the E-stage controller, latches the operands, and counts the fixed unit latency. It commits results to the HI/LO registers and asserts the D-stage stall request, so that no MD instruction enters E while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- E_md_op  in  4  E-stage MD opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others are treated as NONE
- E_rs_data  in  32  forwarded rs value in E
- E_rt_data  in  32  forwarded rt value in E
- D_is_md  in  1  D-stage instruction is any MD op (opcodes 1–8)
- md_start  out  1  combinational: E_md_op is 1–4 and state is IDLE
- md_busy  out  1  registered: state is RUN
- md_stall  out  1  combinational: D_is_md && (md_start || md_busy)
- md_rdata  out  32  combinational: HI for MFHI, LO for MFLO, else 0
- md_hi  out  32  HI register
- md_lo  out  32  LO register

Decided: one clock; reset is synchronous and active-high, ports named clk and reset.

## Operation
- State machine with two states, IDLE and RUN, plus a counter cnt sized for DIV_CYCLES.
- IDLE, md_start:
  - Latch the pending results pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Pending result values:
  - MULT: signed 64-bit product; HI = [63:32], LO = [31:0].
  - MULTU: unsigned 64-bit product.
  - DIV: LO = signed quotient, HI = signed remainder; remainder takes the sign of the dividend (truncating division).
  - DIVU: unsigned quotient and remainder.
  - Divisor 0: set a pend_keep flag; HI/LO stay unchanged at commit, but busy timing is unchanged.
- RUN:
  - cnt decrements each cycle.
  - When cnt == 1, the next edge commits pend_hi/pend_lo to HI/LO (unless pend_keep) and returns to IDLE.
- MTHI/MTLO in IDLE: HI or LO is written with E_rs_data at the next edge.
- MFHI/MFLO: md_rdata reflects the current registers and is not stalled by the unit itself; D stalls while busy.
- Any MD opcode in E while in RUN is ignored. The stall makes this unreachable; the bench asserts it never occurs.
- E-stage results from MFHI/MFLO have Tnew = 1, the same as ALU ops.

## Timing
- Cycle 0: MULT in E; md_start = 1; if D_is_md then md_stall = 1.
- Cycles 1..MULT_CYCLES: md_busy = 1.
- HI/LO show the new value in cycle MULT_CYCLES+1, when md_busy = 0.
- DIV follows the same pattern with DIV_CYCLES.
- Back-to-back: an MD op stalled in D enters E in the first cycle with busy = 0 and starts there. The gap between consecutive busy windows is exactly one cycle.
- Reset values, on any cycle including mid-RUN:
  - state IDLE, cnt 0, HI 0, LO 0, pend_* 0, md_busy 0.
  - A pending result is discarded.
- Reset has priority over start and commit in the same cycle.
- Non-MD instructions in D never stall because of this block.

## Structure
- Shared package or header: the MD opcode defines (MD_NONE … MD_MTLO), MULT_CYCLES and DIV_CYCLES defaults, and the state encodings. These are shared with the E_controller decode that produces E_md_op.
- Natural sub-module: md_arith, purely combinational. It takes op, a and b, and returns {hi, lo, keep}. This isolates signed/unsigned multiply and divide from the sequencing logic.
- Pending results are latched at start, so the arithmetic may be replaced by an iterative unit without changing the external timing.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3:
  - md_busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU rs=17, rt=5:
  - busy for 10 cycles.
  - Then LO=3, HI=2.
  - DIV rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by zero with HI=0x11, LO=0x22:
  - 10 busy cycles.
  - HI/LO stay 0x11/0x22.
- MULT followed by MFLO in D:
  - md_stall is high in the start cycle and during all 5 busy cycles.
  - MFLO reads the new LO the cycle after busy drops.
- MTHI 0xDEADBEEF then MFHI: md_rdata = 0xDEADBEEF. A non-MD instruction in D during busy has md_stall = 0.
- Reset asserted in busy cycle 3 of a DIV:
  - Next cycle md_busy=0, HI=LO=0.
  - The old result is never committed.
